// File: rtl/fifo_h2f_stream_reader.sv
// fifo_h2f_stream_reader
// Polls the HPS->FPGA FIFO fill level over the CSR slave, drains words in
// bounded bursts over the out slave, and presents them to fabric logic as a
// 32-bit valid/ready stream through a small skid FIFO.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for enable, poll timer expiry and a free skid entry
// POLL      | one-cycle CSR read of the fill level
// POLL_WAIT | fill level returned; size the burst or back off
// DRAIN     | issuing out-slave reads until the burst is exhausted
module fifo_h2f_stream_reader #(
    parameter int BUF_DEPTH     = 4,
    parameter int MAX_BURST     = 8,
    parameter int POLL_INTERVAL = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    input  logic [31:0] out_readdata,
    output logic        out_read,
    input  logic        out_waitrequest,
    output logic [2:0]  csr_address,
    output logic        csr_read,
    output logic [31:0] csr_writedata,
    output logic        csr_write,
    input  logic [31:0] csr_readdata,
    output logic [31:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic [31:0] words_rcvd,
    output logic        busy
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(POLL_INTERVAL + 1);

    localparam logic [CW-1:0] DEPTH_C     = CW'(BUF_DEPTH);
    localparam logic [31:0]   MAX_B32     = 32'(MAX_BURST);
    localparam logic [7:0]    MAX_B8      = 8'(MAX_BURST);
    localparam logic [TW-1:0] POLL_RELOAD = TW'(POLL_INTERVAL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POLL,
        S_POLL_WAIT,
        S_DRAIN
    } state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     rem_q, rem_d;
    logic [31:0]    words_q;

    logic [31:0]    mem_q [BUF_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;

    logic           full;
    logic           pop;
    logic           accept;
    logic [CW-1:0]  free_cnt;
    logic [7:0]     free8;
    logic [7:0]     fill_cap;
    logic [7:0]     burst;
    logic [7:0]     rem_next;

    assign full     = (count_q == DEPTH_C);
    assign free_cnt = DEPTH_C - count_q;
    assign free8    = 8'(free_cnt);
    assign st_valid = (count_q != '0);
    assign st_data  = mem_q[rd_ptr_q];
    assign pop      = st_valid && st_ready;

    // A pop in the same cycle frees the entry the incoming word will use.
    assign out_read = (state_q == S_DRAIN) && (rem_q != 8'd0) && (!full || pop);
    assign accept   = out_read && !out_waitrequest;

    assign csr_address   = 3'd0;
    assign csr_read      = (state_q == S_POLL);
    assign csr_writedata = 32'd0;
    assign csr_write     = 1'b0;
    assign words_rcvd    = words_q;
    assign busy          = (state_q != S_IDLE);

    // Burst size: fill snapshot clipped to the burst limit and to the skid room.
    always_comb begin
        fill_cap = (csr_readdata > MAX_B32) ? MAX_B8 : csr_readdata[7:0];
        burst    = (fill_cap > free8) ? free8 : fill_cap;
    end

    // Next-state logic for the polling/draining sequencer.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rem_d    = rem_q;
        rem_next = rem_q - {7'd0, accept};
        // A read stalled by waitrequest must be carried to completion even
        // when enable drops; otherwise stop issuing after this cycle.
        if (!enable && !(out_read && out_waitrequest)) begin
            rem_next = 8'd0;
        end
        case (state_q)
            S_IDLE: begin
                if (enable && (timer_q == '0) && !full) begin
                    state_d = S_POLL;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_POLL: begin
                state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (burst == 8'd0) begin
                    state_d = S_IDLE;
                    timer_d = POLL_RELOAD;
                end else begin
                    state_d = S_DRAIN;
                    rem_d   = burst;
                end
            end
            S_DRAIN: begin
                rem_d = rem_next;
                if (rem_next == 8'd0) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                rem_d   = 8'd0;
            end
        endcase
    end

    // Sequencer registers and accepted-word counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            rem_q   <= 8'd0;
            words_q <= 32'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            if (accept) begin
                words_q <= words_q + 32'd1;
            end
        end
    end

    // Skid FIFO: push on accepted word, pop on stream handshake.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= out_readdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
